// File: rtl/hid_lock_leds.sv
// Keyboard lock-LED controller: toggles Num/Caps/Scroll on new key presses,
// accepts a software override, and issues rate-limited LED update strobes.
module hid_lock_leds #(
    parameter int unsigned HOLDOFF_CYCLES = 12000
) (
    input  logic       usbclk,
    input  logic       usbrst,
    input  logic [1:0] typ,
    input  logic       report,
    input  logic [7:0] key1,
    input  logic [7:0] key2,
    input  logic [7:0] key3,
    input  logic [7:0] key4,
    input  logic       conerr,
    input  logic       force_we,
    input  logic [3:0] force_leds,
    output logic [3:0] leds,
    output logic       update_leds_stb
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES);
    localparam logic [7:0] KEY_NUM      = 8'h53;
    localparam logic [7:0] KEY_CAPS     = 8'h39;
    localparam logic [7:0] KEY_SCROLL   = 8'h47;
    localparam logic [7:0] KEY_ROLLOVER = 8'h01;
    localparam logic [1:0] TYP_KBD      = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STB  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       prev_present;
    logic             pending;
    logic [1:0]       typ_q;

    logic [2:0] present;
    logic [2:0] rise;
    logic       kbd_take;
    logic       other_rep;
    logic       force_take;
    logic       attach;
    logic       set_ev;

    // Decode the report into lock-key presence and the events that request a strobe
    always_comb begin
        present[0] = (key1 == KEY_NUM)    || (key2 == KEY_NUM)    ||
                     (key3 == KEY_NUM)    || (key4 == KEY_NUM);
        present[1] = (key1 == KEY_CAPS)   || (key2 == KEY_CAPS)   ||
                     (key3 == KEY_CAPS)   || (key4 == KEY_CAPS);
        present[2] = (key1 == KEY_SCROLL) || (key2 == KEY_SCROLL) ||
                     (key3 == KEY_SCROLL) || (key4 == KEY_SCROLL);
        rise       = present & ~prev_present;
        kbd_take   = report && (typ == TYP_KBD) && !conerr && (key1 != KEY_ROLLOVER);
        other_rep  = report && (typ != TYP_KBD) && !conerr;
        force_take = force_we && !conerr;
        attach     = (typ == TYP_KBD) && (typ_q != TYP_KBD) && !conerr;
        set_ev     = (kbd_take && (rise != 3'b000)) || force_take || attach;
    end

    always_ff @(posedge usbclk) begin
        if (usbrst) begin
            leds            <= 4'b0000;
            update_leds_stb <= 1'b0;
            prev_present    <= 3'b000;
            pending         <= 1'b0;
            typ_q           <= 2'd0;
            state           <= ST_IDLE;
            cnt             <= '0;
        end else if (conerr) begin
            // Connection lost: drop everything except the LED value itself
            update_leds_stb <= 1'b0;
            prev_present    <= 3'b000;
            pending         <= 1'b0;
            typ_q           <= 2'd0;
            state           <= ST_IDLE;
            cnt             <= '0;
        end else begin
            typ_q           <= typ;
            update_leds_stb <= 1'b0;

            if (force_take) begin
                leds <= force_leds;
            end else if (kbd_take) begin
                leds[2:0] <= leds[2:0] ^ rise;
            end

            if (kbd_take) begin
                prev_present <= present;
            end else if (other_rep) begin
                prev_present <= 3'b000;
            end

            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        state           <= ST_STB;
                        update_leds_stb <= 1'b1;
                    end
                end
                ST_STB: begin
                    cnt   <= HOLD_LOAD;
                    state <= (HOLDOFF_CYCLES > 1) ? ST_HOLD : ST_IDLE;
                end
                ST_HOLD: begin
                    // Leave HOLD as the count steps down to 1 so the idle gap equals the holdoff
                    cnt <= cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(2)) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (set_ev) begin
                pending <= 1'b1;
            end else if (state == ST_STB) begin
                pending <= 1'b0;
            end
        end
    end

endmodule
